// File: rtl/exception_controller_if.sv
// Request and CP0/PC-control signals between decode/execute, the exception
// sequencer and the CP0 register block.
interface exception_controller_if #(
    parameter int CNT_W = 8
);
    logic             exc_valid;
    logic [6:0]       exc_flags;
    logic [31:0]      exc_pc;
    logic             eret_req;
    logic [31:0]      cp0_status;
    logic [31:0]      cp0_epc;

    logic             cp0_wen;
    logic [31:0]      cp0_epc_in;
    logic [4:0]       cp0_exccode;
    logic             eret_executed;
    logic             pc_redirect;
    logic [31:0]      pc_target;
    logic             flush;
    logic             cpu_stall;
    logic             halted;
    logic [CNT_W-1:0] exc_count;

    // Upstream side: raises requests and observes the sequencer.
    modport master (
        output exc_valid, exc_flags, exc_pc, eret_req, cp0_status, cp0_epc,
        input  cp0_wen, cp0_epc_in, cp0_exccode, eret_executed, pc_redirect,
        input  pc_target, flush, cpu_stall, halted, exc_count
    );

    // Sequencer side.
    modport slave (
        input  exc_valid, exc_flags, exc_pc, eret_req, cp0_status, cp0_epc,
        output cp0_wen, cp0_epc_in, cp0_exccode, eret_executed, pc_redirect,
        output pc_target, flush, cpu_stall, halted, exc_count
    );
endinterface

// File: rtl/exception_controller.sv
// Multi-cycle exception/ERET sequencer feeding the CP0 write port and PC redirect.
//
// state | meaning
// IDLE  | accepting exception / ERET requests, no stall
// WRITE | writing EPC and ExcCode into CP0
// REDIR | redirecting PC to the exception vector
// ERET  | clearing EXL and redirecting PC to EPC
// HALT  | nested exception; stalled until reset
module exception_controller #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
    parameter int          CNT_W      = 8
) (
    input logic                   clk,
    input logic                   reset,
    exception_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        REDIR = 3'd2,
        ERET  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    state_t             state, state_nxt;
    logic [31:0]        epc_q;
    logic [31:0]        target_q;
    logic [4:0]         code_q;
    logic [CNT_W-1:0]   count_q;

    logic               exc_hit;
    logic               exl;
    logic               take_exc;
    logic               take_ri;
    logic               take_eret;
    logic               go_halt;
    logic [4:0]         code_sel;
    logic               unused_status;

    assign unused_status = ^{bus.cp0_status[31:2], bus.cp0_status[0]};

    // Flag order {adel_if, ri, ov, sys, bp, adel_ld, ades}: MSB wins.
    always_comb begin
        code_sel = 5'd0;
        if (bus.exc_flags[6])      code_sel = CODE_ADEL;
        else if (bus.exc_flags[5]) code_sel = CODE_RI;
        else if (bus.exc_flags[4]) code_sel = CODE_OV;
        else if (bus.exc_flags[3]) code_sel = CODE_SYS;
        else if (bus.exc_flags[2]) code_sel = CODE_BP;
        else if (bus.exc_flags[1]) code_sel = CODE_ADEL;
        else if (bus.exc_flags[0]) code_sel = CODE_ADES;
    end

    // An exception always beats a same-cycle ERET; ERET outside EXL is an RI.
    always_comb begin
        exc_hit   = bus.exc_valid && (bus.exc_flags != 7'd0);
        exl       = bus.cp0_status[1];
        take_exc  = (state == IDLE) && exc_hit && !exl;
        go_halt   = (state == IDLE) && exc_hit && exl;
        take_ri   = (state == IDLE) && !exc_hit && bus.eret_req && !exl;
        take_eret = (state == IDLE) && !exc_hit && bus.eret_req && exl;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go_halt)                   state_nxt = HALT;
                else if (take_exc || take_ri)  state_nxt = WRITE;
                else if (take_eret)            state_nxt = ERET;
            end
            WRITE:   state_nxt = REDIR;
            REDIR:   state_nxt = IDLE;
            ERET:    state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            epc_q    <= 32'd0;
            target_q <= 32'd0;
            code_q   <= 5'd0;
            count_q  <= '0;
        end else begin
            state <= state_nxt;
            if (take_exc) begin
                epc_q  <= bus.exc_pc;
                code_q <= code_sel;
            end else if (take_ri) begin
                epc_q  <= bus.exc_pc;
                code_q <= CODE_RI;
            end
            if (take_eret) begin
                target_q <= bus.cp0_epc;
            end
            if ((take_exc || take_ri) && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        bus.cp0_wen       = 1'b0;
        bus.cp0_epc_in    = 32'd0;
        bus.cp0_exccode   = 5'd0;
        bus.eret_executed = 1'b0;
        bus.pc_redirect   = 1'b0;
        bus.pc_target     = 32'd0;
        bus.flush         = 1'b0;
        bus.cpu_stall     = 1'b0;
        bus.halted        = 1'b0;
        case (state)
            WRITE: begin
                bus.cp0_wen     = 1'b1;
                bus.cp0_epc_in  = epc_q;
                bus.cp0_exccode = code_q;
                bus.cpu_stall   = 1'b1;
            end
            REDIR: begin
                bus.pc_redirect = 1'b1;
                bus.flush       = 1'b1;
                bus.pc_target   = EXC_VECTOR;
                bus.cpu_stall   = 1'b1;
            end
            ERET: begin
                bus.eret_executed = 1'b1;
                bus.pc_redirect   = 1'b1;
                bus.flush         = 1'b1;
                bus.pc_target     = target_q;
                bus.cpu_stall     = 1'b1;
            end
            HALT: begin
                bus.cpu_stall = 1'b1;
                bus.halted    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.exc_count = count_q;

endmodule

// File: tb/tb_exception_controller.sv
// Directed self-checking bench for exception_controller.
module tb_exception_controller;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   wen_seen;
    int   redir_seen;

    exception_controller_if #(.CNT_W(8)) bus ();

    exception_controller #(
        .EXC_VECTOR (32'h0000_0380),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request at the next rising edge, then sample #1 after it.
    task automatic fire(input logic valid, input logic [6:0] flags, input logic [31:0] pc,
                        input logic eret);
        @(negedge clk);
        bus.exc_valid = valid;
        bus.exc_flags = flags;
        bus.exc_pc    = pc;
        bus.eret_req  = eret;
        @(posedge clk);
        #1;
        bus.exc_valid = 1'b0;
        bus.exc_flags = 7'd0;
        bus.eret_req  = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0] flags;
        logic [4:0] code;
    } prio_vec_t;

    prio_vec_t prio_tbl[6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        prio_tbl[0] = '{7'b1111111, 5'd4};
        prio_tbl[1] = '{7'b0001100, 5'd8};
        prio_tbl[2] = '{7'b0000001, 5'd5};
        prio_tbl[3] = '{7'b0110000, 5'd10};
        prio_tbl[4] = '{7'b0000110, 5'd9};
        prio_tbl[5] = '{7'b0000011, 5'd4};

        bus.exc_valid  = 1'b0;
        bus.exc_flags  = 7'd0;
        bus.exc_pc     = 32'd0;
        bus.eret_req   = 1'b0;
        bus.cp0_status = 32'd0;
        bus.cp0_epc    = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_wen",    {31'd0, bus.cp0_wen},     32'd0);
        check_val("rst_stall",  {31'd0, bus.cpu_stall},   32'd0);
        check_val("rst_halted", {31'd0, bus.halted},      32'd0);
        check_val("rst_target", bus.pc_target,            32'd0);
        check_val("rst_count",  {24'd0, bus.exc_count},   32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Overflow exception, full latency walk
        fire(1'b1, 7'b0010000, 32'h0000_0040, 1'b0);
        check_val("ov_wen",     {31'd0, bus.cp0_wen},       32'd1);
        check_val("ov_epc",     bus.cp0_epc_in,             32'h40);
        check_val("ov_code",    {27'd0, bus.cp0_exccode},   32'd12);
        check_val("ov_stall1",  {31'd0, bus.cpu_stall},     32'd1);
        check_val("ov_redir1",  {31'd0, bus.pc_redirect},   32'd0);
        step();
        check_val("ov_redir",   {31'd0, bus.pc_redirect},   32'd1);
        check_val("ov_flush",   {31'd0, bus.flush},         32'd1);
        check_val("ov_target",  bus.pc_target,              32'h380);
        check_val("ov_wen2",    {31'd0, bus.cp0_wen},       32'd0);
        check_val("ov_count",   {24'd0, bus.exc_count},     32'd1);
        step();
        check_val("ov_idle",    {31'd0, bus.cpu_stall},     32'd0);

        // Priority encoding
        foreach (prio_tbl[i]) begin
            fire(1'b1, prio_tbl[i].flags, 32'h1000 + 32'(i * 4), 1'b0);
            check_val("prio_code", {27'd0, bus.cp0_exccode}, {27'd0, prio_tbl[i].code});
            check_val("prio_epc",  bus.cp0_epc_in, 32'h1000 + 32'(i * 4));
            step();
            step();
        end
        check_val("prio_count", {24'd0, bus.exc_count}, 32'd7);

        // Valid strobe with no flags is not a request
        fire(1'b1, 7'd0, 32'h0000_0500, 1'b0);
        check_val("noflag_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("noflag_count", {24'd0, bus.exc_count}, 32'd7);

        // ERET with EXL set
        bus.cp0_status = 32'h0000_0002;
        bus.cp0_epc    = 32'h0000_0044;
        fire(1'b0, 7'd0, 32'h0000_0600, 1'b1);
        check_val("eret_exec",   {31'd0, bus.eret_executed}, 32'd1);
        check_val("eret_redir",  {31'd0, bus.pc_redirect},   32'd1);
        check_val("eret_flush",  {31'd0, bus.flush},         32'd1);
        check_val("eret_target", bus.pc_target,              32'h44);
        check_val("eret_wen",    {31'd0, bus.cp0_wen},       32'd0);
        step();
        check_val("eret_idle",   {31'd0, bus.cpu_stall},     32'd0);
        check_val("eret_count",  {24'd0, bus.exc_count},     32'd7);

        // ERET without EXL behaves as reserved instruction
        bus.cp0_status = 32'h0000_0000;
        fire(1'b0, 7'd0, 32'h0000_0100, 1'b1);
        check_val("eri_wen",  {31'd0, bus.cp0_wen},       32'd1);
        check_val("eri_code", {27'd0, bus.cp0_exccode},   32'd10);
        check_val("eri_epc",  bus.cp0_epc_in,             32'h100);
        check_val("eri_exec", {31'd0, bus.eret_executed}, 32'd0);
        step();
        check_val("eri_exec2", {31'd0, bus.eret_executed}, 32'd0);
        check_val("eri_target", bus.pc_target, 32'h380);
        step();
        check_val("eri_count", {24'd0, bus.exc_count}, 32'd8);

        // Exception and ERET together: exception wins (bp code)
        fire(1'b1, 7'b0000100, 32'h0000_0200, 1'b1);
        check_val("sim_code", {27'd0, bus.cp0_exccode},   32'd9);
        check_val("sim_epc",  bus.cp0_epc_in,             32'h200);
        step();
        check_val("sim_exec", {31'd0, bus.eret_executed}, 32'd0);
        step();
        check_val("sim_count", {24'd0, bus.exc_count}, 32'd9);

        // Second exc_valid during WRITE is ignored
        @(negedge clk);
        bus.exc_valid = 1'b1;
        bus.exc_flags = 7'b0001000;
        bus.exc_pc    = 32'h0000_0300;
        wen_seen = 0;
        step();
        if (bus.cp0_wen) wen_seen++;
        step();
        bus.exc_valid = 1'b0;
        bus.exc_flags = 7'd0;
        if (bus.cp0_wen) wen_seen++;
        repeat (3) begin
            step();
            if (bus.cp0_wen) wen_seen++;
        end
        check_val("ign_wen_pulses", 32'(wen_seen), 32'd1);
        check_val("ign_count", {24'd0, bus.exc_count}, 32'd10);

        // Nested exception -> HALT
        bus.cp0_status = 32'h0000_0002;
        fire(1'b1, 7'b0010000, 32'h0000_0400, 1'b0);
        check_val("dbl_halted", {31'd0, bus.halted},    32'd1);
        check_val("dbl_stall",  {31'd0, bus.cpu_stall}, 32'd1);
        wen_seen = 0;
        redir_seen = 0;
        bus.exc_valid = 1'b1;
        bus.exc_flags = 7'b0010000;
        bus.eret_req  = 1'b1;
        repeat (20) begin
            step();
            if (bus.cp0_wen) wen_seen++;
            if (bus.pc_redirect) redir_seen++;
        end
        bus.exc_valid = 1'b0;
        bus.exc_flags = 7'd0;
        bus.eret_req  = 1'b0;
        check_val("dbl_no_wen",   32'(wen_seen),   32'd0);
        check_val("dbl_no_redir", 32'(redir_seen), 32'd0);
        check_val("dbl_held",     {31'd0, bus.halted}, 32'd1);
        check_val("dbl_count",    {24'd0, bus.exc_count}, 32'd10);

        // Asynchronous reset clears HALT
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_halt_clr", {31'd0, bus.halted},    32'd0);
        check_val("rst_halt_stl", {31'd0, bus.cpu_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset pulse in the middle of WRITE
        bus.cp0_status = 32'h0000_0000;
        fire(1'b1, 7'b0100000, 32'h0000_0700, 1'b0);
        check_val("mid_wen_pre", {31'd0, bus.cp0_wen}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_wen",   {31'd0, bus.cp0_wen},     32'd0);
        check_val("mid_epc",   bus.cp0_epc_in,           32'd0);
        check_val("mid_code",  {27'd0, bus.cp0_exccode}, 32'd0);
        check_val("mid_stall", {31'd0, bus.cpu_stall},   32'd0);
        check_val("mid_count", {24'd0, bus.exc_count},   32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_val("mid_after", {31'd0, bus.pc_redirect}, 32'd0);

        // 300 back-to-back exceptions: counter saturates at 255
        @(negedge clk);
        bus.exc_valid = 1'b1;
        bus.exc_flags = 7'b0010000;
        bus.exc_pc    = 32'h0000_0800;
        wen_seen = 0;
        for (int c = 0; c < 900; c++) begin
            step();
            if (bus.cp0_wen) wen_seen++;
            if (c == 761) check_val("sat_254", {24'd0, bus.exc_count}, 32'd254);
        end
        bus.exc_valid = 1'b0;
        bus.exc_flags = 7'd0;
        check_val("sat_pulses", 32'(wen_seen), 32'd300);
        check_val("sat_count",  {24'd0, bus.exc_count}, 32'd255);
        repeat (5) step();
        check_val("sat_hold",   {24'd0, bus.exc_count}, 32'd255);
        check_val("sat_idle",   {31'd0, bus.cpu_stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
Multi-cycle CPU exception sequencer. It sits directly upstream of the CP0 register block and downstream of decode/execute. It takes per-instruction exception flags and ERET requests, prioritises them, and drives the CP0 write port (wen, EPC, ExcCode) and the ERET-executed strobe. It also stalls the main control FSM and redirects the PC to the handler vector or back to EPC.

Parameters:
EXC_VECTOR, 32'h0000_0380, PC loaded on exception entry
CNT_W, 8, width of the saturating taken-exception counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
exc_valid  input  1  one-cycle strobe: current instruction raised one or more exception flags
exc_flags  input  7  {adel_if, ri, ov, sys, bp, adel_ld, ades}, bit 6 = adel_if; sampled with exc_valid
exc_pc  input  32  PC of the faulting instruction; sampled with exc_valid
eret_req  input  1  one-cycle strobe: decode recognised ERET
cp0_status  input  32  CP0 Status; bit 1 = EXL
cp0_epc  input  32  CP0 EPC
cp0_wen  output  1  CP0 write enable
cp0_epc_in  output  32  EPC value to write
cp0_exccode  output  5  ExcCode to write into Cause[6:2]
eret_executed  output  1  one-cycle strobe to CP0, clears EXL
pc_redirect  output  1  one-cycle strobe: load pc_target into PC
pc_target  output  32  redirect address
flush  output  1  discard the in-flight instruction's remaining writes; high with pc_redirect
cpu_stall  output  1  hold the main control FSM
halted  output  1  sticky double-fault indicator
exc_count  output  CNT_W  number of exceptions taken, saturating

Behaviour:
- Reset: state IDLE. All outputs 0, pc_target 0, latched EPC/code 0, exc_count 0. Reset is asynchronous, so asserting it in any state returns to IDLE immediately and clears halted.
- States: IDLE, WRITE, REDIR, ERET, HALT. State, latched EPC, latched code and latched target are registers. Outputs decode from the state register only; no combinational path from inputs to outputs.
- Requests are sampled only in IDLE. In all other states exc_valid and eret_req are ignored. Upstream holds them off via cpu_stall.
- ExcCode priority, highest first: adel_if=4, ri=10, ov=12, sys=8, bp=9, adel_ld=4, ades=5. The winner alone is latched.
- exc_valid=1 with exc_flags=0: treated as no request.
- IDLE, exc_valid with nonzero flags, EXL=0: latch exc_pc and code, go to WRITE. exc_count increments, saturating at all-ones.
- IDLE, exc_valid with nonzero flags, EXL=1 (nested exception): go to HALT. No CP0 write.
- IDLE, eret_req, EXL=1: latch cp0_epc as target, go to ERET.
- IDLE, eret_req, EXL=0: treated as RI. Latch exc_pc with code 10, go to WRITE, and exc_count increments.
- IDLE, exc_valid and eret_req in the same cycle: the exception wins and eret_req is dropped.
- WRITE, one cycle: cp0_wen=1, cp0_epc_in=latched PC, cp0_exccode=latched code, cpu_stall=1. Next state REDIR.
- REDIR, one cycle: pc_redirect=1, flush=1, pc_target=EXC_VECTOR, cpu_stall=1. Next state IDLE.
- ERET, one cycle: eret_executed=1, pc_redirect=1, flush=1, pc_target=latched EPC, cpu_stall=1. Next state IDLE.
- HALT: cpu_stall=1 and halted=1 held until reset. All other outputs 0.
- Latency:
  - exception strobe at edge N gives cp0_wen in cycle N+1 and pc_redirect in N+2; IDLE again at N+3.
  - ERET strobe at edge N gives eret_executed and pc_redirect in cycle N+1; IDLE at N+2.
- cp0_wen and eret_executed are never high in the same cycle.
- cpu_stall is low only in IDLE.

Test Plan:
- Overflow: EXL=0, exc_valid with exc_flags=7'b0010000 and exc_pc=32'h0000_0040 -> cycle+1: cp0_wen=1, cp0_epc_in=32'h40, cp0_exccode=12; cycle+2: pc_redirect=1, flush=1, pc_target=32'h380; exc_count=1.
- Priority: exc_flags=7'b1111111 -> exccode=4 (adel_if); exc_flags=7'b0001100 -> exccode=8 (sys beats bp); exc_flags=7'b0000001 -> exccode=5.
- ERET: EXL=1, cp0_epc=32'h0000_0044, eret_req -> cycle+1: eret_executed=1, pc_redirect=1, pc_target=32'h44, cp0_wen=0. With EXL=0 instead -> cp0_wen=1 with exccode=10 and no eret_executed.
- Simultaneous/ignored requests: exc_valid and eret_req together -> only the exception path runs. A second exc_valid during WRITE is ignored: exactly one cp0_wen pulse and exc_count increments by one.
- Double fault and reset: EXL=1 with exc_valid -> halted=1, cpu_stall=1, and no cp0_wen for 20 cycles. Pulse reset mid-WRITE -> all outputs 0 immediately.
- Saturation: 300 back-to-back exceptions with EXL forced to 0 -> exc_count=255 and holds.
